// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the Type A controller and the execute unit.
// The controller is the master; the execute stage is the slave.
interface alu_muldiv_if;
  logic        start;
  logic [3:0]  funct;
  logic [15:0] op1;
  logic [15:0] op2;
  logic [15:0] result;
  logic [15:0] r15_out;
  logic        r15_we;
  logic        done;
  logic        busy;
  logic        dz;

  modport master (
    output start, funct, op1, op2,
    input  result, r15_out, r15_we, done, busy, dz
  );

  modport slave (
    input  start, funct, op1, op2,
    output result, r15_out, r15_we, done, busy, dz
  );
endinterface

// File: rtl/alu_muldiv.sv
// Type A execute stage: one-cycle ALU ops plus a 16-step sequential
// signed multiply/divide with an R15 side result.
module alu_muldiv (
  input logic       clk,
  input logic       reset,
  alu_muldiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b0001;
  localparam logic [3:0] F_AND = 4'b0010;
  localparam logic [3:0] F_OR  = 4'b0011;
  localparam logic [3:0] F_MUL = 4'b0100;
  localparam logic [3:0] F_DIV = 4'b0101;
  localparam logic [3:0] F_SLL = 4'b1000;
  localparam logic [3:0] F_SRA = 4'b1001;

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  fn;
  logic [15:0] op1_q;
  logic [15:0] m;
  logic        sa;
  logic        sb;
  // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
  logic [32:0] acc;

  logic [15:0] abs1;
  logic [15:0] abs2;
  logic        is_md;
  logic        in_mul;
  logic        fn_mul;
  logic [15:0] simple;
  logic [16:0] mul_hi;
  logic [16:0] div_r;
  logic [16:0] div_d;
  logic        ge;
  logic [31:0] prod;
  logic [15:0] quo;
  logic [15:0] rem;

  always_comb begin
    abs1   = bus.op1[15] ? 16'(-bus.op1) : bus.op1;
    abs2   = bus.op2[15] ? 16'(-bus.op2) : bus.op2;
    in_mul = bus.funct == F_MUL;
    is_md  = in_mul || bus.funct == F_DIV;
    fn_mul = fn == F_MUL;
    case (bus.funct)
      F_ADD:   simple = bus.op1 + bus.op2;
      F_SUB:   simple = bus.op1 - bus.op2;
      F_AND:   simple = bus.op1 & bus.op2;
      F_OR:    simple = bus.op1 | bus.op2;
      F_SLL:   simple = bus.op1 << bus.op2[3:0];
      F_SRA:   simple = 16'($signed(bus.op1) >>> bus.op2[3:0]);
      default: simple = 16'h0000;
    endcase
    mul_hi = acc[32:16] + {1'b0, m};
    div_r  = acc[31:15];
    ge     = div_r >= {1'b0, m};
    div_d  = div_r - {1'b0, m};
    prod   = (sa ^ sb) ? 32'(-acc[31:0]) : acc[31:0];
    quo    = (sa ^ sb) ? 16'(-acc[15:0]) : acc[15:0];
    rem    = sa ? 16'(-acc[31:16]) : acc[31:16];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      fn          <= 4'd0;
      op1_q       <= 16'h0;
      m           <= 16'h0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      acc         <= 33'h0;
      bus.result  <= 16'h0;
      bus.r15_out <= 16'h0;
      bus.r15_we  <= 1'b0;
      bus.done    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.dz      <= 1'b0;
    end else begin
      bus.done   <= 1'b0;
      bus.r15_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start && is_md) begin
            state    <= RUN;
            bus.busy <= 1'b1;
            cnt      <= 4'd0;
            fn       <= bus.funct;
            op1_q    <= bus.op1;
            sa       <= bus.op1[15];
            sb       <= bus.op2[15];
            m        <= in_mul ? abs1 : abs2;
            acc      <= {17'h0, in_mul ? abs2 : abs1};
          end else if (bus.start) begin
            bus.result <= simple;
            bus.dz     <= 1'b0;
            bus.done   <= 1'b1;
          end
        end
        RUN: begin
          if (fn_mul)
            acc <= acc[0] ? {mul_hi, acc[15:0]} >> 1 : acc >> 1;
          else
            acc <= ge ? {div_d, acc[14:0], 1'b1}
                      : {div_r, acc[14:0], 1'b0};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) state <= FIX;
        end
        FIX: begin
          state      <= IDLE;
          bus.busy   <= 1'b0;
          bus.done   <= 1'b1;
          bus.r15_we <= 1'b1;
          if (fn_mul) begin
            bus.result  <= prod[15:0];
            bus.r15_out <= prod[31:16];
            bus.dz      <= 1'b0;
          end else if (m == 16'h0) begin
            bus.result  <= 16'hFFFF;
            bus.r15_out <= op1_q;
            bus.dz      <= 1'b1;
          end else begin
            bus.result  <= quo;
            bus.r15_out <= rem;
            bus.dz      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
